// File: rtl/dlx_pkg.sv
// Shared DLX encodings: ALU operation codes, opcodes, R-type func codes and
// the decoded-control bundle that crosses the ID/EX boundary.
package dlx_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_SLE = 4'd3;
    localparam logic [3:0] ALU_SGT = 4'd4;
    localparam logic [3:0] ALU_SGE = 4'd5;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd9;
    localparam logic [3:0] ALU_SRL = 4'd10;
    localparam logic [3:0] ALU_SEQ = 4'd11;
    localparam logic [3:0] ALU_SNE = 4'd12;
    localparam logic [3:0] ALU_AND = 4'd13;
    localparam logic [3:0] ALU_OR  = 4'd14;
    localparam logic [3:0] ALU_XOR = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDUI = 6'h09;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_SUBUI = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_SLLI  = 6'h14;
    localparam logic [5:0] OP_SRLI  = 6'h16;
    localparam logic [5:0] OP_SRAI  = 6'h17;
    localparam logic [5:0] OP_SEQI  = 6'h18;
    localparam logic [5:0] OP_SNEI  = 6'h19;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_SGTI  = 6'h1B;
    localparam logic [5:0] OP_SLEI  = 6'h1C;
    localparam logic [5:0] OP_SGEI  = 6'h1D;
    localparam logic [5:0] OP_LOAD_FIRST  = 6'h20;
    localparam logic [5:0] OP_LOAD_LAST   = 6'h25;
    localparam logic [5:0] OP_STORE_FIRST = 6'h28;
    localparam logic [5:0] OP_STORE_LAST  = 6'h2B;

    localparam logic [5:0] FN_NOP  = 6'h00;
    localparam logic [5:0] FN_SLL  = 6'h04;
    localparam logic [5:0] FN_SRL  = 6'h06;
    localparam logic [5:0] FN_SRA  = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SEQ  = 6'h28;
    localparam logic [5:0] FN_SNE  = 6'h29;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SGT  = 6'h2B;
    localparam logic [5:0] FN_SLE  = 6'h2C;
    localparam logic [5:0] FN_SGE  = 6'h2D;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       use_imm;
        logic       imm_signed;
        logic       check_of;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/func decoder producing the ALU control bundle.
module alu_ctrl_decode
    import dlx_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output logic [3:0] ctrl_o,
    output logic       use_imm_o,
    output logic       imm_signed_o,
    output logic       check_of_o,
    output logic       illegal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        ctrl_o       = ALU_ADD;
        use_imm_o    = 1'b0;
        imm_signed_o = 1'b0;
        check_of_o   = 1'b0;
        illegal_o    = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_NOP:  ctrl_o = ALU_ADD;
                    FN_ADD:  begin ctrl_o = ALU_ADD; check_of_o = 1'b1; end
                    FN_ADDU: ctrl_o = ALU_ADD;
                    FN_SUB:  begin ctrl_o = ALU_SUB; check_of_o = 1'b1; end
                    FN_SUBU: ctrl_o = ALU_SUB;
                    FN_AND:  ctrl_o = ALU_AND;
                    FN_OR:   ctrl_o = ALU_OR;
                    FN_XOR:  ctrl_o = ALU_XOR;
                    FN_SLL:  ctrl_o = ALU_SLL;
                    FN_SRL:  ctrl_o = ALU_SRL;
                    FN_SRA:  ctrl_o = ALU_SRA;
                    FN_SEQ:  ctrl_o = ALU_SEQ;
                    FN_SNE:  ctrl_o = ALU_SNE;
                    FN_SLT:  ctrl_o = ALU_SLT;
                    FN_SGT:  ctrl_o = ALU_SGT;
                    FN_SLE:  ctrl_o = ALU_SLE;
                    FN_SGE:  ctrl_o = ALU_SGE;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDUI, OP_SUBI, OP_SUBUI, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLLI, OP_SRLI, OP_SRAI, OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI,
            OP_SLEI, OP_SGEI: begin
                use_imm_o    = 1'b1;
                // Logical immediates and the unsigned arithmetic forms zero-extend.
                imm_signed_o = !(opcode_i inside {OP_ADDUI, OP_SUBUI, OP_ANDI, OP_ORI, OP_XORI});
                check_of_o   = (opcode_i inside {OP_ADDI, OP_SUBI});
                case (opcode_i)
                    OP_SUBI, OP_SUBUI: ctrl_o = ALU_SUB;
                    OP_ANDI: ctrl_o = ALU_AND;
                    OP_ORI:  ctrl_o = ALU_OR;
                    OP_XORI: ctrl_o = ALU_XOR;
                    OP_SLLI: ctrl_o = ALU_SLL;
                    OP_SRLI: ctrl_o = ALU_SRL;
                    OP_SRAI: ctrl_o = ALU_SRA;
                    OP_SEQI: ctrl_o = ALU_SEQ;
                    OP_SNEI: ctrl_o = ALU_SNE;
                    OP_SLTI: ctrl_o = ALU_SLT;
                    OP_SGTI: ctrl_o = ALU_SGT;
                    OP_SLEI: ctrl_o = ALU_SLE;
                    OP_SGEI: ctrl_o = ALU_SGE;
                    default: ctrl_o = ALU_ADD;
                endcase
            end
            // Branches test rs1 against zero through the ALU zero flag.
            OP_BEQZ, OP_BNEZ: ctrl_o = ALU_SEQ;
            OP_J, OP_JAL, OP_JR, OP_JALR: ctrl_o = ALU_ADD;
            default: begin
                if (opcode_i inside {[OP_LOAD_FIRST:OP_LOAD_LAST],
                                     [OP_STORE_FIRST:OP_STORE_LAST]}) begin
                    use_imm_o    = 1'b1;
                    imm_signed_o = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX boundary register for ALU control: stall/flush priority, valid bit
// and the sticky illegal-instruction flag.
module alu_ctrl_stage
    import dlx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:31] instr,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        illegal_clr,
    output logic [0:3]  ctrl,
    output logic        use_imm,
    output logic        imm_signed,
    output logic        check_of,
    output logic        ex_valid,
    output logic        illegal,
    output logic        illegal_seen
);

    logic [3:0] dec_ctrl;
    logic       dec_use_imm, dec_imm_signed, dec_check_of, dec_illegal;
    dec_t       dec, dec_d, dec_q;
    logic       valid_d, valid_q;
    logic       seen_d, seen_q;
    logic       instr_unused;

    assign instr_unused = ^instr[6:25];

    alu_ctrl_decode u_decode (
        .opcode_i     (instr[0:5]),
        .func_i       (instr[26:31]),
        .ctrl_o       (dec_ctrl),
        .use_imm_o    (dec_use_imm),
        .imm_signed_o (dec_imm_signed),
        .check_of_o   (dec_check_of),
        .illegal_o    (dec_illegal)
    );

    assign dec = '{ctrl: dec_ctrl, use_imm: dec_use_imm, imm_signed: dec_imm_signed,
                   check_of: dec_check_of, illegal: dec_illegal};

    always_comb begin
        dec_d   = dec_q;
        valid_d = valid_q;
        if (flush) begin
            dec_d   = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            dec_d   = in_valid ? dec : '0;
        end

        // A new illegal capture outranks a simultaneous clear.
        seen_d = seen_q;
        if (illegal_clr)
            seen_d = 1'b0;
        if (!flush && !stall && in_valid && dec.illegal)
            seen_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= '0;
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
        end
    end

    assign ctrl         = dec_q.ctrl;
    assign use_imm      = dec_q.use_imm;
    assign imm_signed   = dec_q.imm_signed;
    assign check_of     = dec_q.check_of;
    assign illegal      = dec_q.illegal;
    assign ex_valid     = valid_q;
    assign illegal_seen = seen_q;

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered ID/EX-boundary decoder that turns a fetched 32-bit DLX instruction word into the 4-bit `ctrl` code, operand-select and overflow-check controls consumed by the execute-stage ALU. It sits between the decode stage and the ALU as the producing end of the ALU's control interface. It carries a valid bit through the boundary and honours pipeline stall and flush. It also keeps a sticky illegal-instruction flag for the exception logic.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in [0:31]: instruction word from the decode stage.
  - Bit 0 is the MSB.
  - `opcode = instr[0:5]`, `func = instr[26:31]`.
- `in_valid` in 1: `instr` holds a real instruction.
- `stall` in 1: hold all registered outputs.
- `flush` in 1: replace the captured instruction with a bubble.
- `illegal_clr` in 1: clear `illegal_seen`.
- `ctrl` out [0:3]: ALU operation code, registered.
- `use_imm` out 1: the ALU B operand is the immediate, not rs2.
- `imm_signed` out 1: sign-extend the 16-bit immediate. When low, zero-extend it.
- `check_of` out 1: the ALU `of` output raises an overflow trap.
- `ex_valid` out 1: the EX stage holds a real instruction.
- `illegal` out 1: the instruction in EX is undecodable. Registered.
- `illegal_seen` out 1: sticky; set by any illegal instruction that reaches EX.

## Operation
- ctrl encoding:
  - 0 add, 1 sub, 2 slt, 3 sle, 4 sgt, 5 sge, 7 sra, 9 sll, 10 srl, 11 seq, 12 sne, 14 or, 15 xor.
  - AND uses 13. Codes 6 and 8 are never emitted.
- R-type (`opcode` 0x00), selected by `func`:
  - add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26
  - sll 0x04, srl 0x06, sra 0x07
  - seq 0x28, sne 0x29, slt 0x2A, sgt 0x2B, sle 0x2C, sge 0x2D
  - `use_imm` = 0.
  - Opcode 0x00 with `func` = 0 is a NOP: `ctrl` = 0 and `illegal` = 0.
- I-type (`use_imm` = 1):
  - addi 0x08, addui 0x09, subi 0x0A, subui 0x0B, andi 0x0C, ori 0x0D, xori 0x0E
  - slli 0x14, srli 0x16, srai 0x17
  - seqi 0x18, snei 0x19, slti 0x1A, sgti 0x1B, slei 0x1C, sgei 0x1D
- Loads 0x20–0x25 and stores 0x28–0x2B: `ctrl` = add, `use_imm` = 1, `imm_signed` = 1.
- Branches beqz 0x04 and bnez 0x05: `ctrl` = seq (11), `use_imm` = 0. Execute compares rs1 against zero through the ALU `zero` flag.
- Jumps j 0x02, jal 0x03, jr 0x12, jalr 0x13: `ctrl` = add, `use_imm` = 0.
- `imm_signed` = 0 only for addui, subui, andi, ori and xori. It is 1 for every other immediate form.
- `check_of` = 1 only for add, sub, addi and subi.
- Any other opcode/func combination:
  - `illegal` = 1, `ctrl` = 0.
  - `use_imm`, `imm_signed` and `check_of` are all 0.
- Register update priority on each clock edge, highest first:
  1. `flush`: bubble. `ex_valid` = 0, `illegal` = 0, `ctrl` = 0 and all flags 0.
  2. `stall`: hold every registered output.
  3. Otherwise capture the decode of `instr`. `ex_valid` = `in_valid`.
     - When `in_valid` = 0, `illegal` = 0 and all decode outputs are 0.
- Flush beats stall when both are high.
- `illegal_seen` is set on the edge that loads a valid illegal instruction.
  - `illegal_clr` clears it.
  - If set and clear happen in the same cycle, set wins.
  - A flushed or stalled cycle never sets it.

## Timing
- Latency: one cycle, from `instr` to the registered outputs.
- No combinational path from any input to any output.
- Reset (`rst_n` low, asynchronous, at any time including mid-stall):
  - `ctrl` = 0, `use_imm` = 0, `imm_signed` = 0, `check_of` = 0
  - `ex_valid` = 0, `illegal` = 0, `illegal_seen` = 0
- First capture is on the first rising edge after `rst_n` deasserts.
- Stall may last any number of cycles. Outputs stay bit-identical throughout.

## Structure
- Shared package `dlx_pkg`:
  - 4-bit ALU op constants: `ALU_ADD` … `ALU_XOR`, matching the encoding above.
  - 6-bit opcode constants and 6-bit func constants.
- The ALU imports the same op constants.
- One sub-module `alu_ctrl_decode`: purely combinational; `opcode`/`func` in, the five decode signals out.
- `alu_ctrl_stage` holds only the registers, the stall/flush priority and the sticky flag.

## Test plan
- Reset mid-run: assert `rst_n` low while `ex_valid` = 1 -> all outputs are 0 immediately, without waiting for a clock edge.
- R-type sweep: each listed `func` with `in_valid` = 1 -> next cycle `ctrl` matches the table.
  - Example: func 0x07 -> `ctrl` = 7.
  - Example: func 0x24 -> `ctrl` = 13.
  - `use_imm` = 0 throughout.
- I-type and memory sweep:
  - addui (0x09) -> `ctrl` = 0, `use_imm` = 1, `imm_signed` = 0, `check_of` = 0.
  - lw (0x23) -> `ctrl` = 0, `imm_signed` = 1.
  - beqz (0x04) -> `ctrl` = 11.
- Stall/flush:
  - Load subi (0x0A), then hold `stall` for 3 cycles while `instr` changes -> `ctrl` = 1 and `check_of` = 1 are held.
  - Assert `stall` and `flush` together -> next cycle `ex_valid` = 0 and `ctrl` = 0.
- Illegal instruction: opcode 0x3F valid -> `illegal` = 1 and `illegal_seen` = 1.
  - The same opcode with `flush` high -> `illegal_seen` is unchanged.
  - `illegal_clr` in the same cycle as a new illegal capture -> `illegal_seen` stays 1.
- Bubble: `in_valid` = 0 with an illegal `instr` -> `ex_valid` = 0, `illegal` = 0, and `illegal_seen` is not set.
